// File: rtl/exmem_skid_stage_pkg.sv
// Shared EX/MEM pipeline definitions: bundle layout, skid-buffer state encoding,
// occupancy codes and reset values for the write-enable control fields.
package exmem_skid_stage_pkg;

    localparam int unsigned EXMEM_DATA_W   = 32;
    localparam int unsigned EXMEM_REGIDX_W = 5;
    localparam int unsigned EXMEM_WBSEL_W  = 2;
    localparam int unsigned EXMEM_RSEL_W   = 3;
    localparam int unsigned EXMEM_WSEL_W   = 2;

    // Default-width bundle; the stage re-declares the same layout from its own parameters.
    typedef struct packed {
        logic [EXMEM_DATA_W-1:0]   alu;
        logic [EXMEM_DATA_W-1:0]   pcm;
        logic [EXMEM_DATA_W-1:0]   datareg;
        logic [EXMEM_REGIDX_W-1:0] regdindex;
        logic                      regwe;
        logic [EXMEM_WBSEL_W-1:0]  wbsel;
        logic                      memrw;
        logic [EXMEM_RSEL_W-1:0]   rsel;
        logic [EXMEM_WSEL_W-1:0]   wsel;
    } exmem_bundle_t;

    // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } skid_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam logic REGWE_RST = 1'b0;
    localparam logic MEMRW_RST = 1'b0;

    function automatic logic [1:0] occupancy_of(input logic main_vld, input logic skid_vld);
        logic [1:0] occ;
        if (main_vld && skid_vld) begin
            occ = OCC_FULL;
        end else if (main_vld || skid_vld) begin
            occ = OCC_ONE;
        end else begin
            occ = OCC_EMPTY;
        end
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid2.sv
// Generic 2-entry skid buffer: main entry drives the outputs, skid entry absorbs the
// one extra beat that arrives while in_ready (a flop) is still high.
module pipe_skid2
    import exmem_skid_stage_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    skid_state_e          state_q, state_d;
    logic                 in_ready_q;
    logic [PAYLOAD_W-1:0] main_q, skid_q;

    logic acc, deq;
    logic main_vld, skid_vld;
    logic load_main, main_from_skid, load_skid;

    assign main_vld = state_q[0];
    assign skid_vld = state_q[1];
    assign acc      = in_valid & in_ready_q;
    assign deq      = main_vld & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) state_d = StOne;
                end
                StOne: begin
                    if (acc && !deq) begin
                        state_d = StFull;
                    end else if (!acc && deq) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (deq) state_d = StOne;
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state_q)
                StEmpty: begin
                    load_main = acc;
                end
                StOne: begin
                    load_main = acc & deq;
                    load_skid = acc & ~deq;
                end
                StFull: begin
                    load_main      = deq;
                    main_from_skid = 1'b1;
                end
                default: begin
                    load_main = 1'b0;
                end
            endcase
        end
    end

    // Payload holds unless an accept or skid-to-main shift targets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign occupancy = occupancy_of(main_vld, skid_vld);

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage: packs the EX result bundle through a 2-entry skid buffer and
// masks the write enables so bubbles never look like live stores or register writes.
module exmem_skid_stage
    import exmem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REGIDX_W = 5,
    parameter int unsigned WBSEL_W  = 2,
    parameter int unsigned RSEL_W   = 3,
    parameter int unsigned WSEL_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   alu_in,
    input  logic [DATA_W-1:0]   pcm_in,
    input  logic [DATA_W-1:0]   datareg_in,
    input  logic [REGIDX_W-1:0] regdindex_in,
    input  logic                regwe_in,
    input  logic [WBSEL_W-1:0]  wbsel_in,
    input  logic                memrw_in,
    input  logic [RSEL_W-1:0]   rsel_in,
    input  logic [WSEL_W-1:0]   wsel_in,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   alu_out,
    output logic [DATA_W-1:0]   pcm_out,
    output logic [DATA_W-1:0]   datareg_out,
    output logic [REGIDX_W-1:0] regdindex_out,
    output logic                regwe_out,
    output logic [WBSEL_W-1:0]  wbsel_out,
    output logic                memrw_out,
    output logic [RSEL_W-1:0]   rsel_out,
    output logic [WSEL_W-1:0]   wsel_out,

    output logic [1:0]          occupancy
);

    // Same field order as exmem_bundle_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]   alu;
        logic [DATA_W-1:0]   pcm;
        logic [DATA_W-1:0]   datareg;
        logic [REGIDX_W-1:0] regdindex;
        logic                regwe;
        logic [WBSEL_W-1:0]  wbsel;
        logic                memrw;
        logic [RSEL_W-1:0]   rsel;
        logic [WSEL_W-1:0]   wsel;
    } stage_bundle_t;

    localparam int unsigned PAYLOAD_W = $bits(stage_bundle_t);

    stage_bundle_t        in_bundle, out_bundle;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_valid_int;

    always_comb begin
        in_bundle.alu       = alu_in;
        in_bundle.pcm       = pcm_in;
        in_bundle.datareg   = datareg_in;
        in_bundle.regdindex = regdindex_in;
        in_bundle.regwe     = regwe_in;
        in_bundle.wbsel     = wbsel_in;
        in_bundle.memrw     = memrw_in;
        in_bundle.rsel      = rsel_in;
        in_bundle.wsel      = wsel_in;
    end

    pipe_skid2 #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid_int),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign out_bundle = stage_bundle_t'(out_payload);

    assign out_valid     = out_valid_int;
    assign alu_out       = out_bundle.alu;
    assign pcm_out       = out_bundle.pcm;
    assign datareg_out   = out_bundle.datareg;
    assign regdindex_out = out_bundle.regdindex;
    assign wbsel_out     = out_bundle.wbsel;
    assign rsel_out      = out_bundle.rsel;
    assign wsel_out      = out_bundle.wsel;

    assign regwe_out = out_valid_int ? out_bundle.regwe : REGWE_RST;
    assign memrw_out = out_valid_int ? out_bundle.memrw : MEMRW_RST;

endmodule
